pam_sampler: RTL
================

# pam_sampler

Downstream stage of the PAM modulator. Samples the 32-bit PAM product word at a programmable period, scales it to a 16-bit sample, and buffers it in a small FIFO. Samples leave through a valid/ready stream toward the DAC/serializer side. Provides drop accounting when the consumer stalls.

## Interface
- IN_W, 32: width of the PAM product input
- OUT_W, 16: width of the output sample
- DIV_W, 16: width of the sample-period control
- DEPTH, 4: FIFO entries, power of two, ≥2
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  sampling enable
- period  input  DIV_W  sample period in clk cycles, 0 treated as 1
- pam_in  input  IN_W  unsigned PAM product, sampled on strobe
- sample_out  output  OUT_W  FIFO head data
- sample_valid  output  1  FIFO non-empty
- sample_ready  input  1  consumer accepts head when high with sample_valid
- drop_pulse  output  1  one-cycle pulse: a strobe hit a full FIFO
- drop_cnt  output  8  saturating count of dropped samples

## Operation
- Period counter `cnt`, 0..P-1, where P = max(period,1). Increments while en=1. Wraps to 0 after P-1.
- Strobe when en=1 and cnt==P-1. On strobe, pam_in is scaled and pushed.
- en=0: cnt forced to 0, no strobes; FIFO continues to drain.
- period changed mid-count: new P used immediately. If cnt ≥ new P-1, the next cycle strobes and cnt wraps to 0.
- Scaling: take the top OUT_W bits of pam_in, i.e. pam_in[IN_W-1:IN_W-OUT_W] (MSB-first numeric value). Rounding is set by the macro; see Configuration.
- FIFO: push on strobe; pop when sample_valid && sample_ready.
- Full + strobe + pop in the same cycle: push accepted, no drop.
- Full + strobe without pop: sample discarded, drop_pulse=1 for one cycle, drop_cnt += 1. drop_cnt saturates at 255.
- Empty + strobe: data is visible on sample_out the next cycle. There is no same-cycle bypass.
- sample_out holds the head value while sample_valid && !sample_ready. It is stable under backpressure.
- sample_out when empty is don't-care, but is driven 0 after reset.

## Timing
- Reset (rst=0, asynchronous) values: cnt=0, FIFO empty, sample_out=0, sample_valid=0, drop_pulse=0, drop_cnt=0.
- Reset release: the first strobe occurs P cycles after en is first seen high, at cnt==P-1.
- Latency: strobe edge to sample_valid is 1 cycle.
- Throughput: one sample per cycle at P=1 with sample_ready held high. No bubbles; occupancy stays ≤1.
- Reset asserted mid-operation: FIFO contents are lost immediately. drop_cnt clears.
- drop_pulse is registered and asserts the cycle after the offending strobe edge.

## Configuration
- PAM_SAMPLER_ROUND_EN defined: round half-up by adding pam_in bit IN_W-OUT_W-1 to the top field. Saturate to all-ones when the top field is already all-ones.
- Not defined: plain truncation of the top OUT_W bits. No adder is instantiated.

## Structure
- Shared package pam_pkg: PAM_IN_W=32, PAM_OUT_W=16, default DIV_W, and a sample typedef of PAM_OUT_W bits, shared with the modulator and sine generator.
- One sub-module, pam_sample_fifo: parameterised DEPTH/width, synchronous push/pop, with full/empty from the pointer MSB compare and the same async active-low reset.
- The period counter, scaling, and drop logic live in the top module.

## Test plan
- Reset: rst=0 with traffic running → every output 0 within the same cycle. After release with en=1 and period=4, first sample_valid rises 5 cycles after release (strobe at cnt=3, plus 1).
- Scaling: pam_in=0x1234_8000, period=1 → sample_out=0x1235 with the macro, 0x1234 without. pam_in=0xFFFF_8000 → 0xFFFF in both builds.
- Backpressure: sample_ready=0, period=1, DEPTH=4, pam_in incrementing → 4 entries held. 6 more strobes give 6 drop_pulses and drop_cnt=6. On release, the first 4 pushed values come out in order.
- Full simultaneous push/pop: FIFO full, sample_ready=1, period=1 → no drop_pulse, stream continuous, order preserved.
- period=0 and period=1 behave identically, with a strobe every cycle. Switching period 10→2 while cnt=7 → strobe next cycle, then every 2 cycles.
- Saturation: 300 dropped strobes → drop_cnt=255 and stays 255. en=0 → no further pushes while the FIFO drains.

Source files
------------

// File: rtl/pam_pkg.sv
// pam_pkg: widths and the sample type shared by the PAM modulator chain.
package pam_pkg;
    localparam int PAM_IN_W  = 32;
    localparam int PAM_OUT_W = 16;
    localparam int PAM_DIV_W = 16;
    typedef logic [PAM_OUT_W-1:0] sample_t;
endpackage

// File: rtl/pam_sample_fifo.sv
// pam_sample_fifo: small sample FIFO; full/empty come from the extra pointer MSB.
module pam_sample_fifo import pam_pkg::*; #(
    parameter int W     = PAM_OUT_W,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_pop;
    logic         w_push;
    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    // Memory is cleared on reset so the head reads 0 while empty.
    assign o_data  = r_mem[r_rd[AW-1:0]];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr[AW-1:0]] <= i_data;
                r_wr <= r_wr + (AW+1)'(1);
            end
            if (w_pop) r_rd <= r_rd + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/pam_sampler.sv
// pam_sampler: periodic sampling of the PAM product into a FIFO'd 16-bit stream.
// PAM_SAMPLER_ROUND_EN selects saturating round-half-up; otherwise plain truncation.
module pam_sampler import pam_pkg::*; #(
    parameter int IN_W  = PAM_IN_W,
    parameter int OUT_W = PAM_OUT_W,
    parameter int DIV_W = PAM_DIV_W,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_period,
    input  logic [IN_W-1:0]  i_pam_in,
    output logic [OUT_W-1:0] o_sample_out,
    output logic             o_sample_valid,
    input  logic             i_sample_ready,
    output logic             o_drop_pulse,
    output logic [7:0]       o_drop_cnt
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;
    logic             w_strobe;
    logic [OUT_W-1:0] w_top;
    logic [OUT_W-1:0] w_sample;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    // ">=" lets a period shrunk below the current count strobe at once.
    assign w_last   = (i_period == '0) ? '0 : i_period - DIV_W'(1);
    assign w_strobe = i_en && (r_cnt >= w_last);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= (!i_en || w_strobe) ? '0 : r_cnt + DIV_W'(1);
    end
    assign w_top = i_pam_in[IN_W-1 -: OUT_W];
`ifdef PAM_SAMPLER_ROUND_EN
    assign w_sample = (&w_top) ? w_top : w_top + OUT_W'(i_pam_in[IN_W-OUT_W-1]);
`else
    assign w_sample = w_top;
`endif
    assign o_sample_valid = !w_empty;
    assign w_pop  = o_sample_valid && i_sample_ready;
    assign w_push = w_strobe && (!w_full || w_pop);
    assign w_drop = w_strobe && w_full && !w_pop;
    pam_sample_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_sample),
        .i_pop   (w_pop),
        .o_data  (o_sample_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop_pulse <= 1'b0;
            o_drop_cnt   <= '0;
        end else begin
            o_drop_pulse <= w_drop;
            if (w_drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end
endmodule
